// File: rtl/fifo_ptr_pkg.sv
// Shared Johnson-pointer helpers for the async FIFO write and read pointer generators.
// Functions work on a wide pointer so any depth up to MAX_DEPTH can use them.
package fifo_ptr_pkg;

  localparam int MAX_DEPTH = 256;
  localparam int PW        = $clog2(MAX_DEPTH);

  typedef logic [MAX_DEPTH-1:0] jptr_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return $clog2(2 * depth);
  endfunction

  // Shift left by one and feed the inverted MSB back into bit 0.
  function automatic jptr_t johnson_next(input jptr_t ptr, input int depth);
    jptr_t nxt;
    nxt    = '0;
    nxt[0] = ~ptr[PW'(depth - 1)];
    for (int i = 1; i < MAX_DEPTH; i++) begin
      if (i < depth) nxt[PW'(i)] = ptr[PW'(i - 1)];
    end
    return nxt;
  endfunction

  function automatic int johnson_to_idx(input jptr_t ptr, input int depth);
    int p;
    p = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (i < depth) p = p + int'(ptr[PW'(i)]);
    end
    return ptr[PW'(depth - 1)] ? (2 * depth - p) : p;
  endfunction

endpackage

// File: rtl/johnson_idx_dec.sv
// Combinational decode of a DEPTH-bit Johnson pointer into its ring index 0..2*DEPTH-1.
module johnson_idx_dec
  import fifo_ptr_pkg::*;
#(
  parameter  int DEPTH = 10,
  localparam int IW    = idx_width(DEPTH)
) (
  input  logic [DEPTH-1:0] ptr_i,
  output logic [IW-1:0]    idx_o
);

  jptr_t ptr_ext;

  assign ptr_ext = jptr_t'(ptr_i);
  assign idx_o   = IW'(johnson_to_idx(ptr_ext, DEPTH));

endmodule

// File: rtl/w_ptr_gen_n.sv
// Write-side pointer and flag generator for the async FIFO: binary RAM address,
// Johnson write pointer, and registered full / almost-full / level / overflow flags.
module w_ptr_gen_n
  import fifo_ptr_pkg::*;
#(
  parameter  int DEPTH    = 10,
  parameter  int AFULL_TH = DEPTH - 2,
  localparam int AW       = addr_width(DEPTH),
  localparam int LW       = level_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INC,
  input  logic             OVF_CLR,
  input  logic [DEPTH-1:0] R_PTR,
  output logic [AW-1:0]    W_ADDR,
  output logic [DEPTH-1:0] W_PTR,
  output logic             W_FULL,
  output logic             W_AFULL,
  output logic [LW-1:0]    W_LEVEL,
  output logic             W_OVF
);

  localparam int IW   = idx_width(DEPTH);
  localparam int RING = 2 * DEPTH;

  logic [DEPTH-1:0] ptr_q, ptr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             we;
  logic [IW-1:0]    idx_w, idx_r;
  logic [IW:0]      diff;

  johnson_idx_dec #(.DEPTH(DEPTH)) u_dec_w (
    .ptr_i (ptr_d),
    .idx_o (idx_w)
  );

  johnson_idx_dec #(.DEPTH(DEPTH)) u_dec_r (
    .ptr_i (R_PTR),
    .idx_o (idx_r)
  );

  // A write requested while full is dropped; pointer and address hold.
  always_comb begin
    we     = INC & ~full_q;
    ptr_d  = ptr_q;
    addr_d = addr_q;
    if (we) begin
      ptr_d  = DEPTH'(johnson_next(jptr_t'(ptr_q), DEPTH));
      addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  // Flags look at the post-write pointer so a filling write raises full on the same edge.
  always_comb begin
    diff = {1'b0, idx_w} + (IW+1)'(RING) - {1'b0, idx_r};
    if (diff >= (IW+1)'(RING)) diff = diff - (IW+1)'(RING);
    level_d = LW'(diff);
    full_d  = (ptr_d == ~R_PTR);
    afull_d = (level_d >= LW'(AFULL_TH));
    ovf_d   = (INC & full_q) | (ovf_q & ~OVF_CLR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q   <= '0;
      addr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_PTR   = ptr_q;
  assign W_ADDR  = addr_q;
  assign W_LEVEL = level_q;
  assign W_FULL  = full_q;
  assign W_AFULL = afull_q;
  assign W_OVF   = ovf_q;

endmodule

// File: doc/w_ptr_gen_n.md
Name: w_ptr_gen_n

Overview:
Parametrised write-side pointer/flag generator for the asynchronous FIFO. It produces a binary RAM write address and a DEPTH-bit Johnson-coded write pointer for any FIFO depth, not only depth 10. The Johnson pointer is the value crossed to the read domain. From the already-synchronized read pointer it derives registered full, almost-full, fill-level and sticky overflow flags. It sits in the write clock domain between the write-request logic and the dual-port RAM / pointer synchronizer.

Parameters:
DEPTH, 10, number of FIFO entries (>=2); Johnson pointer width = DEPTH bits, giving 2*DEPTH states.
AW, $clog2(DEPTH), RAM address width (derived, do not override).
LW, $clog2(DEPTH+1), fill-level width (derived).
AFULL_TH, DEPTH-2, W_AFULL asserts when level >= AFULL_TH (1..DEPTH).

Ports:
CLK  input  1  write-domain clock
RST  input  1  asynchronous active-low reset
INC  input  1  write request for this cycle
OVF_CLR  input  1  synchronous clear of W_OVF
R_PTR  input  DEPTH  read Johnson pointer, already synchronized into CLK domain
W_ADDR  output  AW  RAM write address, binary 0..DEPTH-1
W_PTR  output  DEPTH  write Johnson pointer
W_FULL  output  1  FIFO full
W_AFULL  output  1  level >= AFULL_TH
W_LEVEL  output  LW  entries written and not yet read, 0..DEPTH
W_OVF  output  1  sticky: INC seen while W_FULL=1

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-low.
- Reset values: all outputs 0 (W_ADDR=0, W_PTR=0, flags 0, W_LEVEL=0). Reset asserted mid-operation clears everything immediately, regardless of INC.
- Accepted write: WE = INC & !W_FULL. A write requested while full is dropped: pointer and address hold.
- On WE, W_PTR <= {W_PTR[DEPTH-2:0], ~W_PTR[DEPTH-1]}. Otherwise W_PTR holds.
- On WE, W_ADDR <= (W_ADDR==DEPTH-1) ? 0 : W_ADDR+1. W_ADDR holds otherwise; it never leaves 0..DEPTH-1.
- Johnson decode to index k in 0..2*DEPTH-1, with p = popcount(ptr):
  - MSB=0: k = p.
  - MSB=1: k = 2*DEPTH - p.
- Level: lvl_nxt = (k(PTR_NXT) - k(R_PTR)) mod 2*DEPTH. Result is always 0..DEPTH when the read side is legal.
- Full: W_FULL_NXT = (PTR_NXT == ~R_PTR), i.e. the write pointer is exactly DEPTH states ahead. This is equivalent to lvl_nxt == DEPTH.
- Registered flags: W_FULL, W_AFULL and W_LEVEL are registered from PTR_NXT and the current R_PTR, and update every cycle, not only on INC.
  - A write that fills the FIFO raises W_FULL on the same edge that advances W_PTR.
  - An R_PTR advance clears W_FULL one CLK edge after it is seen.
- Simultaneous INC with W_FULL=1 and an R_PTR advance in the same cycle: the write is dropped because W_FULL was 1. W_FULL deasserts next edge and W_OVF sets.
- W_OVF: sets on INC & W_FULL and stays set until OVF_CLR. If OVF_CLR and a new overflow occur in the same cycle, set wins.
- Latency: INC to W_PTR/W_ADDR update is 1 edge. R_PTR change to flag update is 1 edge.
- Illegal R_PTR (non-Johnson code) is undefined. The assertion bench flags it; RTL does not check it.

Decomposition:
- Package fifo_ptr_pkg:
  - function johnson_next(ptr), shift-with-inversion step.
  - function johnson_to_idx(ptr), popcount decode.
  - localparam helpers for AW/LW.
  - The read-side generator shares this package.
- Sub-module johnson_idx_dec (parameter DEPTH), combinational ptr -> index. It is instantiated twice, for PTR_NXT and R_PTR, and reused by the read-side successor.

Test Plan:
- DEPTH=10, R_PTR=0, INC held 10 cycles -> W_PTR 0x001,0x003,...,0x3FF. W_ADDR 1..9 then 0. W_LEVEL=10, W_FULL=1 after 10th edge, W_AFULL=1 from level 8.
- Continue INC 2 more cycles while full -> W_PTR stays 0x3FF, W_ADDR stays 0, W_OVF=1. OVF_CLR pulse -> W_OVF=0 next edge.
- While full, step R_PTR 0x000->0x001 with INC=0 -> W_FULL=0 and W_LEVEL=9 one edge later. Then INC -> W_PTR=0x3FE, W_FULL=1 again.
- Run 25 writes with R_PTR tracking 3 states behind -> W_PTR wraps through 0x3FF back to 0x000 (index 19->0). W_LEVEL constant 3, W_FULL never 1.
- Reset asserted asynchronously mid-burst (between edges) at W_PTR=0x01F -> all outputs 0 immediately. First INC after release gives W_PTR=0x001, W_ADDR=1.
- DEPTH=5, AFULL_TH=4 -> full at W_PTR=0x1F. AFULL at level 4. W_ADDR wraps 4->0.
